// File: rtl/chunk_serial_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder.
package chunk_serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} csa_state_e;

  // Counter width for NCHUNK slices; a single-slice build still needs one bit.
  function automatic int unsigned csa_cnt_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_serial_adder_if.sv
// Handshake bundle for the chunk-serial adder's operand and result channels.
// out_ovf exists only when CHUNK_SERIAL_ADDER_OVF_EN is defined.
interface chunk_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    output out_ovf,
`endif
    output in_ready, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/chunk_serial_adder_add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder slices.
module add_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle unsigned adder: CHUNK bits per clock with a registered ripple carry.
// Optional signed-overflow flag out_ovf when CHUNK_SERIAL_ADDER_OVF_EN is defined.
module chunk_serial_adder
  import chunk_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  localparam int unsigned CHUNK_SAFE = (CHUNK > 0) ? CHUNK : 1;
  localparam int unsigned NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int unsigned CW         = csa_cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK_SAFE) != 0) begin : g_param_err
    $error("chunk_serial_adder: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
  end

  csa_state_e       r_state, w_state_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic [WIDTH-1:0] r_sum, w_sum_d;
  logic             r_carry, w_carry_d;
  logic             r_cout, w_cout_d;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
  logic             r_ovf, w_ovf_d;
`endif

  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_s;
  logic             w_c;

  assign w_base    = 32'(r_cnt) * CHUNK;
  assign w_a_slice = r_a[w_base +: CHUNK];
  assign w_b_slice = r_b[w_base +: CHUNK];

  add_chunk #(
    .CHUNK (CHUNK)
  ) u_add_chunk (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_c)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_sum_d   = r_sum;
    w_carry_d = r_carry;
    w_cout_d  = r_cout;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    w_ovf_d   = r_ovf;
`endif
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_a_d     = in_a;
          w_b_d     = in_b;
          w_carry_d = in_cin;
          w_cnt_d   = '0;
          w_state_d = BUSY;
        end
      end
      BUSY: begin
        w_sum_d[w_base +: CHUNK] = w_s;
        w_carry_d                = w_c;
        if (r_cnt == LAST_CNT) begin
          w_cout_d  = w_c;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
          // Final slice holds the sum MSB.
          w_ovf_d   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[CHUNK-1] != r_a[WIDTH-1]);
`endif
          w_cnt_d   = '0;
          w_state_d = DONE;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_cnt   <= w_cnt_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_sum   <= w_sum_d;
      r_carry <= w_carry_d;
      r_cout  <= w_cout_d;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
      r_ovf   <= w_ovf_d;
`endif
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
  assign out_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder: 16/4 and 1/1 builds, scoreboard-checked results.
module tb_chunk_serial_adder;

  localparam int unsigned NC = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t       sb[$];
  logic [1:0] sb1[$];

  always #5 clk = ~clk;

  chunk_serial_adder_if #(.WIDTH(16)) bus ();
  chunk_serial_adder_if #(.WIDTH(1))  bus1 ();

  chunk_serial_adder #(
    .WIDTH (16),
    .CHUNK (4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_a      (bus.in_a),
    .in_b      (bus.in_b),
    .in_cin    (bus.in_cin),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_sum   (bus.out_sum),
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    .out_ovf   (bus.out_ovf),
`endif
    .out_cout  (bus.out_cout)
  );

  chunk_serial_adder #(
    .WIDTH (1),
    .CHUNK (1)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus1.in_valid),
    .in_ready  (bus1.in_ready),
    .in_a      (bus1.in_a),
    .in_b      (bus1.in_b),
    .in_cin    (bus1.in_cin),
    .out_valid (bus1.out_valid),
    .out_ready (bus1.out_ready),
    .out_sum   (bus1.out_sum),
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    .out_ovf   (bus1.out_ovf),
`endif
    .out_cout  (bus1.out_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] t;
    exp_t        e;
    t      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.sum  = t[15:0];
    e.cout = t[16];
    e.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
    return e;
  endfunction

  // hold = cycles of out_ready=0 after the result appears; 0 keeps out_ready high throughout.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input int hold);
    exp_t        e;
    int          lat;
    logic [15:0] s0;
    logic        c0;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = cin;
    bus.out_ready = (hold == 0);
    sb.push_back(model(a, b, cin));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = 16'($urandom);
    bus.in_b     = 16'($urandom);
    bus.in_cin   = 1'($urandom);
    chk("in_ready_busy", 32'(bus.in_ready), 0);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, NC);
    e  = sb.pop_front();
    s0 = bus.out_sum;
    c0 = bus.out_cout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_sum", 32'(bus.out_sum), 32'(s0));
      chk("hold_cout", 32'(bus.out_cout), 32'(c0));
      chk("hold_in_ready", 32'(bus.in_ready), 0);
    end
    chk("sum", 32'(bus.out_sum), 32'(e.sum));
    chk("cout", 32'(bus.out_cout), 32'(e.cout));
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    chk("ovf", 32'(bus.out_ovf), 32'(e.ovf));
`endif
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_drop", 32'(bus.out_valid), 0);
    chk("in_ready_after", 32'(bus.in_ready), 1);
    chk("sum_kept", 32'(bus.out_sum), 32'(e.sum));
  endtask

  task automatic run_op1(input logic a, input logic b, input logic cin);
    logic [1:0] e;
    int         lat;
    @(negedge clk);
    bus1.in_valid  = 1'b1;
    bus1.in_a      = a;
    bus1.in_b      = b;
    bus1.in_cin    = cin;
    bus1.out_ready = 1'b1;
    sb1.push_back(2'(a) + 2'(b) + 2'(cin));
    @(negedge clk);
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    chk("w1_latency", lat, 1);
    e = sb1.pop_front();
    chk("w1_sum_cout", 32'({bus1.out_cout, bus1.out_sum}), 32'(e));
    @(negedge clk);
    chk("w1_valid_drop", 32'(bus1.out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic seen;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_cin     = 1'b0;
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.in_cin    = 1'b0;
    bus1.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_sum", 32'(bus.out_sum), 0);
    chk("rst_cout", 32'(bus.out_cout), 0);
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(bus.out_ovf), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b1, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'hA5A5, 16'h5A5B, 1'b1, 5);
    run_op(16'h8000, 16'h8000, 1'b0, 2);

    // Reset two cycles into an operation discards it.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h1111;
    bus.in_b     = 16'h2222;
    bus.in_cin   = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_sum", 32'(bus.out_sum), 0);
    chk("midrst_cout", 32'(bus.out_cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", 32'(seen), 0);
    run_op(16'h0002, 16'h0003, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 8; i++) begin
      run_op1(i[2], i[1], i[0]);
    end

    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
